bus_arbiter: RTL and testbench

Two-requester arbiter sharing one memory port between the core's instruction fetch unit and its load/store path. It sits between `core` and the shared memory/peripheral interconnect, and replaces the separate instruction and data grant sources with one sequenced transaction stream. It runs one transaction at a time: arbitrate, issue, wait for acknowledge, return a grant pulse plus read data.

---
 rtl/bus_arb_pkg.sv | 20 ++
 rtl/bus_arb_pick.sv | 30 +++
 rtl/bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// The optional round-robin tie-break is enabled with BUS_ARB_ROUND_ROBIN_EN.
package bus_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } arbState_e;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner selection between fetch and LSU requests.
// BUS_ARB_ROUND_ROBIN_EN selects alternating ties; otherwise LSU always wins a tie.
module bus_arb_pick
    import bus_arb_pkg::*;
(
    input  logic iReq_i,
    input  logic dReq_i,
`ifdef BUS_ARB_ROUND_ROBIN_EN
    input  logic last_i,
`endif
    output logic valid_o,
    output logic winner_o
);

    always_comb begin
        valid_o  = iReq_i | dReq_i;
        winner_o = OWN_D;
        if (iReq_i && !dReq_i) begin
            winner_o = OWN_I;
        end else if (iReq_i && dReq_i) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
            // A tie goes to whichever side lost the previous arbitration.
            winner_o = (last_i == OWN_D) ? OWN_I : OWN_D;
`else
            winner_o = OWN_D;
`endif
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Sequences fetch and LSU requests onto one memory port, one transaction at a time.
// Tie-break policy follows BUS_ARB_ROUND_ROBIN_EN (see bus_arb_pick).
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_I_REQ,
    input  logic [ADDR_WIDTH-1:0] i_I_ADDR,
    output logic                  o_I_GNT,
    output logic [DATA_WIDTH-1:0] o_I_RDATA,
    input  logic                  i_D_REQ,
    input  logic [ADDR_WIDTH-1:0] i_D_ADDR,
    input  logic [DATA_WIDTH-1:0] i_D_WDATA,
    input  logic                  i_D_WE,
    input  logic [1:0]            i_D_HB,
    output logic                  o_D_GNT,
    output logic [DATA_WIDTH-1:0] o_D_RDATA,
    output logic                  o_MEM_REQ,
    output logic [ADDR_WIDTH-1:0] o_MEM_ADDR,
    output logic [DATA_WIDTH-1:0] o_MEM_WDATA,
    output logic                  o_MEM_WE,
    output logic [1:0]            o_MEM_HB,
    input  logic [DATA_WIDTH-1:0] i_MEM_RDATA,
    input  logic                  i_MEM_ACK,
    output logic                  o_OWNER
);

    arbState_e             state_q,    state_d;
    logic                  memReq_q,   memReq_d;
    logic [ADDR_WIDTH-1:0] memAddr_q,  memAddr_d;
    logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
    logic                  memWe_q,    memWe_d;
    logic [1:0]            memHb_q,    memHb_d;
    logic [DATA_WIDTH-1:0] iRdata_q,   iRdata_d;
    logic [DATA_WIDTH-1:0] dRdata_q,   dRdata_d;
    logic                  iGnt_q,     iGnt_d;
    logic                  dGnt_q,     dGnt_d;
    logic                  owner_q,    owner_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic                  rrLast_q,   rrLast_d;
`endif

    logic pickValid;
    logic pickWinner;

    bus_arb_pick u_pick (
        .iReq_i   (i_I_REQ),
        .dReq_i   (i_D_REQ),
`ifdef BUS_ARB_ROUND_ROBIN_EN
        .last_i   (rrLast_q),
`endif
        .valid_o  (pickValid),
        .winner_o (pickWinner)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= ST_IDLE;
            memReq_q   <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memWe_q    <= 1'b0;
            memHb_q    <= HB_BYTE;
            iRdata_q   <= '0;
            dRdata_q   <= '0;
            iGnt_q     <= 1'b0;
            dGnt_q     <= 1'b0;
            owner_q    <= OWN_I;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            rrLast_q   <= OWN_I;
`endif
        end else begin
            state_q    <= state_d;
            memReq_q   <= memReq_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memWe_q    <= memWe_d;
            memHb_q    <= memHb_d;
            iRdata_q   <= iRdata_d;
            dRdata_q   <= dRdata_d;
            iGnt_q     <= iGnt_d;
            dGnt_q     <= dGnt_d;
            owner_q    <= owner_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            rrLast_q   <= rrLast_d;
`endif
        end
    end

    // GNT is registered on the BUSY->RESP transition so it is high exactly in RESP.
    always_comb begin
        state_d    = state_q;
        memReq_d   = memReq_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memWe_d    = memWe_q;
        memHb_d    = memHb_q;
        iRdata_d   = iRdata_q;
        dRdata_d   = dRdata_q;
        iGnt_d     = 1'b0;
        dGnt_d     = 1'b0;
        owner_d    = owner_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        rrLast_d   = rrLast_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pickValid) begin
                    memReq_d = 1'b1;
                    owner_d  = pickWinner;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    rrLast_d = pickWinner;
`endif
                    if (pickWinner == OWN_D) begin
                        state_d    = ST_BUSY_D;
                        memAddr_d  = i_D_ADDR;
                        memWdata_d = i_D_WDATA;
                        memWe_d    = i_D_WE;
                        memHb_d    = i_D_HB;
                    end else begin
                        state_d    = ST_BUSY_I;
                        memAddr_d  = i_I_ADDR;
                        memWdata_d = '0;
                        memWe_d    = 1'b0;
                        memHb_d    = HB_WORD;
                    end
                end
            end
            ST_BUSY_I: begin
                if (i_MEM_ACK) begin
                    iRdata_d = i_MEM_RDATA;
                    memReq_d = 1'b0;
                    iGnt_d   = 1'b1;
                    state_d  = ST_RESP_I;
                end
            end
            ST_BUSY_D: begin
                if (i_MEM_ACK) begin
                    dRdata_d = i_MEM_RDATA;
                    memReq_d = 1'b0;
                    dGnt_d   = 1'b1;
                    state_d  = ST_RESP_D;
                end
            end
            ST_RESP_I, ST_RESP_D: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                memReq_d = 1'b0;
            end
        endcase
    end

    assign o_I_GNT     = iGnt_q;
    assign o_D_GNT     = dGnt_q;
    assign o_I_RDATA   = iRdata_q;
    assign o_D_RDATA   = dRdata_q;
    assign o_MEM_REQ   = memReq_q;
    assign o_MEM_ADDR  = memAddr_q;
    assign o_MEM_WDATA = memWdata_q;
    assign o_MEM_WE    = memWe_q;
    assign o_MEM_HB    = memHb_q;
    assign o_OWNER     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; expected tie order follows
// BUS_ARB_ROUND_ROBIN_EN the same way the design build does.
module tb_bus_arbiter;

    logic        i_CLK;
    logic        i_RST;
    logic        i_I_REQ;
    logic [31:0] i_I_ADDR;
    logic        o_I_GNT;
    logic [31:0] o_I_RDATA;
    logic        i_D_REQ;
    logic [31:0] i_D_ADDR;
    logic [31:0] i_D_WDATA;
    logic        i_D_WE;
    logic [1:0]  i_D_HB;
    logic        o_D_GNT;
    logic [31:0] o_D_RDATA;
    logic        o_MEM_REQ;
    logic [31:0] o_MEM_ADDR;
    logic [31:0] o_MEM_WDATA;
    logic        o_MEM_WE;
    logic [1:0]  o_MEM_HB;
    logic [31:0] i_MEM_RDATA;
    logic        i_MEM_ACK;
    logic        o_OWNER;

    int checkCount = 0;
    int errorCount = 0;

    bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_I_REQ     (i_I_REQ),
        .i_I_ADDR    (i_I_ADDR),
        .o_I_GNT     (o_I_GNT),
        .o_I_RDATA   (o_I_RDATA),
        .i_D_REQ     (i_D_REQ),
        .i_D_ADDR    (i_D_ADDR),
        .i_D_WDATA   (i_D_WDATA),
        .i_D_WE      (i_D_WE),
        .i_D_HB      (i_D_HB),
        .o_D_GNT     (o_D_GNT),
        .o_D_RDATA   (o_D_RDATA),
        .o_MEM_REQ   (o_MEM_REQ),
        .o_MEM_ADDR  (o_MEM_ADDR),
        .o_MEM_WDATA (o_MEM_WDATA),
        .o_MEM_WE    (o_MEM_WE),
        .o_MEM_HB    (o_MEM_HB),
        .i_MEM_RDATA (i_MEM_RDATA),
        .i_MEM_ACK   (i_MEM_ACK),
        .o_OWNER     (o_OWNER)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    // Outputs are sampled and inputs changed 1ns after each rising edge.
    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic doReset();
        i_RST = 1'b1;
        tick();
        i_RST = 1'b0;
    endtask

    task automatic test_reset();
        i_RST = 1'b1;
        tick();
        tick();
        checkCount++;
        if ({o_MEM_REQ, o_I_GNT, o_D_GNT, o_MEM_WE, o_OWNER} !== 5'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {o_MEM_REQ, o_I_GNT, o_D_GNT, o_MEM_WE, o_OWNER});
        end
        checkCount++;
        if ({o_MEM_ADDR, o_MEM_WDATA, o_MEM_HB} !== 66'h0) begin
            errorCount++;
            $display("[TB] FAIL reset_cmd: got %h expected 0", {o_MEM_ADDR, o_MEM_WDATA, o_MEM_HB});
        end
        checkCount++;
        if ({o_I_RDATA, o_D_RDATA} !== 64'h0) begin
            errorCount++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", {o_I_RDATA, o_D_RDATA});
        end
        i_RST = 1'b0;
        tick();
        checkCount++;
        if (o_MEM_REQ !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_idle: got %b expected 0", o_MEM_REQ);
        end
    endtask

    task automatic test_single_fetch();
        i_I_REQ  = 1'b1;
        i_I_ADDR = 32'h0000_0100;
        tick();
        checkCount++;
        if ({o_MEM_REQ, o_MEM_ADDR, o_MEM_HB, o_MEM_WE, o_OWNER} !== {1'b1, 32'h100, 2'b10, 1'b0, 1'b0}) begin
            errorCount++;
            $display("[TB] FAIL fetch_issue: req=%b addr=%h hb=%b we=%b own=%b expected 1 100 10 0 0",
                     o_MEM_REQ, o_MEM_ADDR, o_MEM_HB, o_MEM_WE, o_OWNER);
        end
        i_MEM_ACK   = 1'b1;
        i_MEM_RDATA = 32'hDEAD_BEEF;
        tick();
        i_MEM_ACK   = 1'b0;
        i_MEM_RDATA = 32'h0;
        i_I_REQ     = 1'b0;
        checkCount++;
        if ({o_I_GNT, o_D_GNT, o_MEM_REQ, o_I_RDATA} !== {3'b100, 32'hDEAD_BEEF}) begin
            errorCount++;
            $display("[TB] FAIL fetch_gnt: ignt=%b dgnt=%b req=%b rdata=%h expected 1 0 0 deadbeef",
                     o_I_GNT, o_D_GNT, o_MEM_REQ, o_I_RDATA);
        end
        tick();
        checkCount++;
        if ({o_I_GNT, o_MEM_REQ} !== 2'b00) begin
            errorCount++;
            $display("[TB] FAIL fetch_done: ignt=%b req=%b expected 0 0", o_I_GNT, o_MEM_REQ);
        end
    endtask

    task automatic test_lsu_store_wait();
        int iGntSeen = 0;
        i_D_REQ   = 1'b1;
        i_D_ADDR  = 32'h0000_2000;
        i_D_WDATA = 32'h1234_5678;
        i_D_WE    = 1'b1;
        i_D_HB    = 2'b01;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (o_I_GNT) iGntSeen++;
            checkCount++;
            if ({o_MEM_REQ, o_MEM_ADDR, o_MEM_WDATA, o_MEM_WE, o_MEM_HB, o_D_GNT}
                    !== {1'b1, 32'h2000, 32'h1234_5678, 1'b1, 2'b01, 1'b0}) begin
                errorCount++;
                $display("[TB] FAIL store_busy%0d: req=%b addr=%h wd=%h we=%b hb=%b dgnt=%b expected 1 2000 12345678 1 01 0",
                         c, o_MEM_REQ, o_MEM_ADDR, o_MEM_WDATA, o_MEM_WE, o_MEM_HB, o_D_GNT);
            end
        end
        i_MEM_ACK   = 1'b1;
        i_MEM_RDATA = 32'hA5A5_0000;
        tick();
        if (o_I_GNT) iGntSeen++;
        i_MEM_ACK = 1'b0;
        i_D_REQ   = 1'b0;
        i_D_WE    = 1'b0;
        checkCount++;
        if ({o_D_GNT, o_MEM_REQ, o_OWNER, o_D_RDATA} !== {3'b101, 32'hA5A5_0000}) begin
            errorCount++;
            $display("[TB] FAIL store_gnt: dgnt=%b req=%b own=%b rdata=%h expected 1 0 1 a5a50000",
                     o_D_GNT, o_MEM_REQ, o_OWNER, o_D_RDATA);
        end
        tick();
        if (o_I_GNT) iGntSeen++;
        checkCount++;
        if (o_D_GNT !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL store_gnt_width: dgnt=%b expected 0", o_D_GNT);
        end
        checkCount++;
        if (iGntSeen != 0) begin
            errorCount++;
            $display("[TB] FAIL store_no_ignt: ignt pulses=%0d expected 0", iGntSeen);
        end
    endtask

    task automatic test_simultaneous();
        logic        expOwner;
        logic [31:0] expAddr;
        doReset();
        i_I_REQ  = 1'b1;
        i_I_ADDR = 32'h0000_0300;
        i_D_REQ  = 1'b1;
        i_D_ADDR = 32'h0000_0400;
        i_D_WE   = 1'b0;
        i_D_HB   = 2'b10;
        for (int k = 0; k < 4; k++) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
            expOwner = (k % 2 == 0) ? 1'b1 : 1'b0;
`else
            expOwner = 1'b1;
`endif
            expAddr = expOwner ? 32'h400 : 32'h300;
            tick();
            checkCount++;
            if ({o_MEM_REQ, o_OWNER, o_MEM_ADDR} !== {1'b1, expOwner, expAddr}) begin
                errorCount++;
                $display("[TB] FAIL tie_issue%0d: req=%b own=%b addr=%h expected 1 %b %h",
                         k, o_MEM_REQ, o_OWNER, o_MEM_ADDR, expOwner, expAddr);
            end
            i_MEM_ACK   = 1'b1;
            i_MEM_RDATA = 32'h0000_1000 + 32'(k);
            tick();
            i_MEM_ACK = 1'b0;
            checkCount++;
            if ({o_D_GNT, o_I_GNT} !== {expOwner, ~expOwner}) begin
                errorCount++;
                $display("[TB] FAIL tie_gnt%0d: dgnt=%b ignt=%b expected %b %b",
                         k, o_D_GNT, o_I_GNT, expOwner, ~expOwner);
            end
            checkCount++;
            if ((expOwner ? o_D_RDATA : o_I_RDATA) !== 32'h0000_1000 + 32'(k)) begin
                errorCount++;
                $display("[TB] FAIL tie_rdata%0d: got %h expected %h",
                         k, (expOwner ? o_D_RDATA : o_I_RDATA), 32'h0000_1000 + 32'(k));
            end
            if (k == 3) begin
                i_I_REQ = 1'b0;
                i_D_REQ = 1'b0;
            end
            tick();
        end
        tick();
        checkCount++;
        if (o_MEM_REQ !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL tie_quiet: req=%b expected 0", o_MEM_REQ);
        end
    endtask

    task automatic test_fetch_drop();
        int pulses = 0;
        i_I_REQ  = 1'b1;
        i_I_ADDR = 32'h0000_0500;
        tick();
        i_I_REQ = 1'b0;
        tick();
        checkCount++;
        if ({o_MEM_REQ, o_MEM_ADDR, o_I_GNT} !== {1'b1, 32'h500, 1'b0}) begin
            errorCount++;
            $display("[TB] FAIL drop_hold: req=%b addr=%h ignt=%b expected 1 500 0", o_MEM_REQ, o_MEM_ADDR, o_I_GNT);
        end
        i_MEM_ACK   = 1'b1;
        i_MEM_RDATA = 32'hCAFE_F00D;
        tick();
        i_MEM_ACK = 1'b0;
        if (o_I_GNT) pulses++;
        checkCount++;
        if (o_I_RDATA !== 32'hCAFE_F00D) begin
            errorCount++;
            $display("[TB] FAIL drop_rdata: got %h expected cafef00d", o_I_RDATA);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (o_I_GNT) pulses++;
        end
        checkCount++;
        if (pulses != 1) begin
            errorCount++;
            $display("[TB] FAIL drop_pulses: got %0d expected 1", pulses);
        end
        checkCount++;
        if (o_MEM_REQ !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL drop_idle: req=%b expected 0", o_MEM_REQ);
        end
    endtask

    task automatic test_reset_mid();
        i_D_REQ  = 1'b1;
        i_D_ADDR = 32'h0000_0600;
        i_D_HB   = 2'b00;
        tick();
        checkCount++;
        if ({o_MEM_REQ, o_OWNER} !== 2'b11) begin
            errorCount++;
            $display("[TB] FAIL rstmid_busy: req=%b own=%b expected 1 1", o_MEM_REQ, o_OWNER);
        end
        i_RST       = 1'b1;
        i_MEM_ACK   = 1'b1;
        i_MEM_RDATA = 32'h7777_7777;
        tick();
        i_RST     = 1'b0;
        i_MEM_ACK = 1'b0;
        i_D_REQ   = 1'b0;
        checkCount++;
        if ({o_MEM_REQ, o_D_GNT, o_I_GNT, o_OWNER, o_MEM_WE, o_MEM_HB, o_MEM_ADDR, o_D_RDATA} !== 71'h0) begin
            errorCount++;
            $display("[TB] FAIL rstmid_zero: req=%b dgnt=%b ignt=%b own=%b addr=%h drdata=%h expected all 0",
                     o_MEM_REQ, o_D_GNT, o_I_GNT, o_OWNER, o_MEM_ADDR, o_D_RDATA);
        end
        tick();
        checkCount++;
        if ({o_D_GNT, o_MEM_REQ} !== 2'b00) begin
            errorCount++;
            $display("[TB] FAIL rstmid_nognt: dgnt=%b req=%b expected 0 0", o_D_GNT, o_MEM_REQ);
        end
        i_I_REQ  = 1'b1;
        i_I_ADDR = 32'h0000_0700;
        tick();
        checkCount++;
        if ({o_MEM_REQ, o_MEM_ADDR, o_OWNER} !== {1'b1, 32'h700, 1'b0}) begin
            errorCount++;
            $display("[TB] FAIL rstmid_fetch_issue: req=%b addr=%h own=%b expected 1 700 0", o_MEM_REQ, o_MEM_ADDR, o_OWNER);
        end
        i_MEM_ACK   = 1'b1;
        i_MEM_RDATA = 32'h1357_9BDF;
        tick();
        i_MEM_ACK = 1'b0;
        i_I_REQ   = 1'b0;
        checkCount++;
        if ({o_I_GNT, o_I_RDATA} !== {1'b1, 32'h1357_9BDF}) begin
            errorCount++;
            $display("[TB] FAIL rstmid_fetch_gnt: ignt=%b rdata=%h expected 1 13579bdf", o_I_GNT, o_I_RDATA);
        end
        tick();
    endtask

    task automatic test_spurious_ack();
        i_MEM_ACK   = 1'b1;
        i_MEM_RDATA = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            checkCount++;
            if ({o_I_GNT, o_D_GNT, o_MEM_REQ} !== 3'b000) begin
                errorCount++;
                $display("[TB] FAIL spurious_gnt%0d: ignt=%b dgnt=%b req=%b expected 0 0 0", c, o_I_GNT, o_D_GNT, o_MEM_REQ);
            end
        end
        i_MEM_ACK = 1'b0;
        checkCount++;
        if ({o_I_RDATA, o_D_RDATA} !== {32'h1357_9BDF, 32'h0}) begin
            errorCount++;
            $display("[TB] FAIL spurious_rdata: irdata=%h drdata=%h expected 13579bdf 00000000", o_I_RDATA, o_D_RDATA);
        end
    endtask

    initial begin
        i_RST       = 1'b1;
        i_I_REQ     = 1'b0;
        i_I_ADDR    = '0;
        i_D_REQ     = 1'b0;
        i_D_ADDR    = '0;
        i_D_WDATA   = '0;
        i_D_WE      = 1'b0;
        i_D_HB      = 2'b00;
        i_MEM_RDATA = '0;
        i_MEM_ACK   = 1'b0;

        test_reset();
        test_single_fetch();
        test_lsu_store_wait();
        test_simultaneous();
        test_fetch_drop();
        test_reset_mid();
        test_spurious_ack();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
